data_release: RTL and testbench

Stream-to-DAC playback block: the transmit-side counterpart of the ADC capture path. It accepts sample frames on an AXI4-Stream slave into a two-buffer ping-pong memory. It replays each completed frame to a DAC interface at one sample per `DAC_MAX_COUNT+1` enabled cycles, and backpressures the stream while both buffers hold unplayed frames.

---
 rtl/data_release.sv | 187 ++++++++++++++++++
 tb/tb_data_release.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_release.sv
// Purpose: ping-pong frame buffer that replays AXI4-Stream sample frames to a paced DAC port.
// Latency: first dac_valid appears DAC_MAX_COUNT+3 cycles after the closing beat (dac_rdy held high).
// Backpressure: s_axis_tready drops while the buffer under the write pointer holds an unplayed frame.
//
// Ports:
//   s_axis_aclk / s_axis_aresetn : clock, asynchronous active-low reset
//   s_axis_t*                    : stream slave (tstrb ignored)
//   dac_rdy                      : DAC enable; pacing only advances while high
//   dac_data / dac_valid         : registered sample and its one-cycle strobe
//   frame_ready                  : some buffer holds a complete unplayed frame
//   underrun / tlast_err         : one-cycle event pulses
//   frames_played                : wrapping count of fully played frames
module data_release #(
  parameter int DATA_WIDTH           = 32,
  parameter int TOTAL_SAMPLES        = 1024,
  parameter int DAC_MAX_COUNT        = 1,
  parameter int C_S_AXIS_TDATA_WIDTH = 32
) (
  input  logic                              s_axis_aclk,
  input  logic                              s_axis_aresetn,
  input  logic                              s_axis_tvalid,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  input  logic                              dac_rdy,
  output logic [DATA_WIDTH-1:0]             dac_data,
  output logic                              dac_valid,
  output logic                              frame_ready,
  output logic                              underrun,
  output logic                              tlast_err,
  output logic [15:0]                       frames_played
);

  localparam int IDX_W  = (TOTAL_SAMPLES > 1) ? $clog2(TOTAL_SAMPLES) : 1;
  localparam int LEN_W  = IDX_W + 1;
  localparam int PACE_W = (DAC_MAX_COUNT > 0) ? $clog2(DAC_MAX_COUNT + 1) : 1;

  typedef enum logic {IDLE, PLAY} state_t;

  // All byte lanes are treated as valid; strobes are deliberately dropped.
  logic unused_tstrb;
  assign unused_tstrb = ^s_axis_tstrb;

  // Sample storage: one bank per buffer, written by the fill side, read by the player.
  logic [DATA_WIDTH-1:0] mem [0:1][0:TOTAL_SAMPLES-1];

  state_t                 state_q, state_d;
  logic [1:0]             full_q, full_d;
  logic [1:0][LEN_W-1:0]  len_q, len_d;
  logic                   wr_sel_q, wr_sel_d;
  logic [IDX_W-1:0]       wr_idx_q, wr_idx_d;
  logic                   rd_sel_q, rd_sel_d;
  logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;
  logic [PACE_W-1:0]      pace_q, pace_d;
  logic                   dac_valid_q, dac_valid_d;
  logic                   underrun_q, underrun_d;
  logic                   tlast_err_q, tlast_err_d;
  logic [15:0]            frames_played_q, frames_played_d;
  logic [DATA_WIDTH-1:0]  dac_data_q;

  logic hs, at_cap, close, start, emit, last_emit, next_full;

  // ---------------- fill side decode ----------------
  always_comb begin
    hs     = s_axis_tvalid & s_axis_tready;
    at_cap = (wr_idx_q == IDX_W'(TOTAL_SAMPLES - 1));
    // A frame closes on tlast or when the buffer is about to run out of room.
    close  = hs & (s_axis_tlast | at_cap);
  end

  // ---------------- player FSM: state register ----------------
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- player FSM: output decode ----------------
  always_comb begin
    // The other buffer's flag is sampled before this edge's close, so a frame
    // closing in the same cycle as a release still costs one idle cycle.
    next_full  = full_q[~rd_sel_q];
    start      = (state_q == IDLE) & full_q[rd_sel_q];
    emit       = (state_q == PLAY) & dac_rdy & (pace_q == PACE_W'(DAC_MAX_COUNT));
    last_emit  = emit & ((LEN_W'(rd_idx_q) + LEN_W'(1)) == len_q[rd_sel_q]);
    underrun_d = last_emit & ~next_full;
  end

  // ---------------- player FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (full_q[rd_sel_q]) state_d = PLAY;
      PLAY:    if (last_emit && !next_full) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    full_d          = full_q;
    len_d           = len_q;
    wr_sel_d        = wr_sel_q;
    wr_idx_d        = wr_idx_q;
    rd_sel_d        = rd_sel_q;
    rd_idx_d        = rd_idx_q;
    pace_d          = pace_q;
    tlast_err_d     = close & at_cap & ~s_axis_tlast;
    dac_valid_d     = emit;
    frames_played_d = frames_played_q;

    if (hs) wr_idx_d = wr_idx_q + IDX_W'(1);
    if (close) begin
      full_d[wr_sel_q] = 1'b1;
      len_d[wr_sel_q]  = LEN_W'(wr_idx_q) + LEN_W'(1);
      wr_sel_d         = ~wr_sel_q;
      wr_idx_d         = '0;
    end

    if (start) begin
      pace_d   = '0;
      rd_idx_d = '0;
    end else if (state_q == PLAY && dac_rdy) begin
      pace_d = emit ? '0 : pace_q + PACE_W'(1);
    end

    if (emit) rd_idx_d = rd_idx_q + IDX_W'(1);
    // Release never targets the buffer being closed: a close needs full clear,
    // a release needs it set.
    if (last_emit) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
      rd_idx_d         = '0;
      frames_played_d  = frames_played_q + 16'd1;
    end
  end

  // ---------------- state registers ----------------
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      full_q          <= '0;
      len_q           <= '0;
      wr_sel_q        <= 1'b0;
      wr_idx_q        <= '0;
      rd_sel_q        <= 1'b0;
      rd_idx_q        <= '0;
      pace_q          <= '0;
      dac_valid_q     <= 1'b0;
      underrun_q      <= 1'b0;
      tlast_err_q     <= 1'b0;
      frames_played_q <= '0;
      dac_data_q      <= '0;
    end else begin
      full_q          <= full_d;
      len_q           <= len_d;
      wr_sel_q        <= wr_sel_d;
      wr_idx_q        <= wr_idx_d;
      rd_sel_q        <= rd_sel_d;
      rd_idx_q        <= rd_idx_d;
      pace_q          <= pace_d;
      dac_valid_q     <= dac_valid_d;
      underrun_q      <= underrun_d;
      tlast_err_q     <= tlast_err_d;
      frames_played_q <= frames_played_d;
      // Synchronous read straight into the output register (BRAM read port);
      // the value holds between strobes.
      if (emit) dac_data_q <= mem[rd_sel_q][rd_idx_q];
    end
  end

  // Write port: no reset, contents are don't-care after reset.
  always_ff @(posedge s_axis_aclk) begin
    if (hs) mem[wr_sel_q][wr_idx_q] <= DATA_WIDTH'(s_axis_tdata);
  end

  assign s_axis_tready = ~full_q[wr_sel_q];
  assign frame_ready   = |full_q;
  assign dac_data      = dac_data_q;
  assign dac_valid     = dac_valid_q;
  assign underrun      = underrun_q;
  assign tlast_err     = tlast_err_q;
  assign frames_played = frames_played_q;

endmodule

// File: tb/tb_data_release.sv
module tb_data_release;
  localparam int DW  = 32;
  localparam int TS  = 1024;
  localparam int DMC = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_axis_tvalid;
  logic [DW-1:0] s_axis_tdata;
  logic [3:0]    s_axis_tstrb;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic          dac_rdy;
  logic [DW-1:0] dac_data;
  logic          dac_valid;
  logic          frame_ready;
  logic          underrun;
  logic          tlast_err;
  logic [15:0]   frames_played;

  data_release #(
    .DATA_WIDTH(DW), .TOTAL_SAMPLES(TS), .DAC_MAX_COUNT(DMC), .C_S_AXIS_TDATA_WIDTH(DW)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_aresetn(rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .dac_rdy       (dac_rdy),
    .dac_data      (dac_data),
    .dac_valid     (dac_valid),
    .frame_ready   (frame_ready),
    .underrun      (underrun),
    .tlast_err     (tlast_err),
    .frames_played (frames_played)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frames are tracked as queues: acc_q is the frame being received, smp_q the
  // samples of all closed-but-unplayed frames in order, len_q their lengths
  // (head = frame currently playing). Occupied buffers == len_q.size().
  logic [31:0] smp_q[$];
  logic [31:0] acc_q[$];
  int          len_q[$];
  bit          m_play;
  int          m_need;   // dac_rdy-high cycles still required before next sample
  int          m_pos;    // samples already emitted from the head frame
  logic [15:0] m_played;
  logic [31:0] m_data;
  bit          m_valid, m_under, m_err;

  // Stimulus source: {tlast, tdata} beats waiting to be offered.
  logic [32:0] src_q[$];
  int          vld_pct;
  int          rdy_mode;   // 0: always high, 1: toggle, 2: random
  bit          rdy_t;

  task automatic model_reset();
    smp_q.delete(); acc_q.delete(); len_q.delete();
    m_play = 0; m_need = 0; m_pos = 0; m_played = '0;
    m_data = '0; m_valid = 0; m_under = 0; m_err = 0;
  endtask

  task automatic push_frame(input int n, input logic [31:0] base, input bit with_last);
    for (int i = 0; i < n; i++)
      src_q.push_back({(with_last && i == n - 1), base + 32'(i)});
  endtask

  // Called at a falling edge: check outputs, drive the next inputs, advance the model one edge.
  task automatic tick();
    bit          vld, rdy, hs;
    logic [32:0] beat;
    chk("tready",        32'(s_axis_tready), 32'(len_q.size() < 2));
    chk("frame_ready",   32'(frame_ready),   32'(len_q.size() > 0));
    chk("dac_valid",     32'(dac_valid),     32'(m_valid));
    chk("dac_data",      dac_data,           m_data);
    chk("underrun",      32'(underrun),      32'(m_under));
    chk("tlast_err",     32'(tlast_err),     32'(m_err));
    chk("frames_played", 32'(frames_played), 32'(m_played));

    vld  = (src_q.size() > 0) && ($urandom_range(99) < vld_pct);
    beat = {1'b0, $urandom()};
    if (vld) beat = src_q[0];
    case (rdy_mode)
      0:       rdy = 1'b1;
      1:       begin rdy_t = ~rdy_t; rdy = rdy_t; end
      default: rdy = 1'($urandom_range(1));
    endcase
    s_axis_tvalid = vld;
    s_axis_tdata  = beat[31:0];
    s_axis_tlast  = beat[32];
    s_axis_tstrb  = 4'($urandom());
    dac_rdy       = rdy;

    hs = vld && (len_q.size() < 2);
    if (hs) void'(src_q.pop_front());

    // Player decisions use the buffer state from before this edge.
    m_valid = 0; m_under = 0; m_err = 0;
    if (!m_play) begin
      if (len_q.size() > 0) begin
        m_play = 1; m_need = DMC + 1; m_pos = 0;
      end
    end else if (rdy) begin
      m_need--;
      if (m_need == 0) begin
        m_data  = smp_q.pop_front();
        m_valid = 1;
        m_need  = DMC + 1;
        m_pos++;
        if (m_pos == len_q[0]) begin
          void'(len_q.pop_front());
          m_played++;
          m_pos = 0;
          if (len_q.size() == 0) begin
            m_play  = 0;
            m_under = 1;
          end
        end
      end
    end

    if (hs) begin
      acc_q.push_back(beat[31:0]);
      if (beat[32] || acc_q.size() == TS) begin
        m_err = !beat[32];
        foreach (acc_q[i]) smp_q.push_back(acc_q[i]);
        len_q.push_back(acc_q.size());
        acc_q.delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((src_q.size() > 0 || len_q.size() > 0 || m_play) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(src_q.size() + len_q.size()), 32'd0);
    repeat (4) tick();
  endtask

  initial begin
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tlast  = 1'b0;
    dac_rdy       = 1'b0;
    rdy_t         = 1'b0;
    vld_pct       = 100;
    rdy_mode      = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 4-beat frame 0x11..0x44, DAC always ready.
    for (int i = 0; i < 4; i++) src_q.push_back({(i == 3), 32'h11 * 32'(i + 1)});
    drain(200);

    // Two back-to-back full-size frames (ramp) plus a third that must wait.
    push_frame(TS, 32'd0, 1'b1);
    push_frame(TS, 32'(TS), 1'b1);
    push_frame(4, 32'hA000_0000, 1'b1);
    drain(7000);

    // 1100 beats, tlast only on the final one: overflow close at 1024, then 76.
    push_frame(TS, 32'h5000_0000, 1'b0);
    push_frame(76, 32'h5000_0000 + 32'(TS), 1'b1);
    drain(7000);

    // DAC ready toggling during playback.
    rdy_mode = 1;
    push_frame(9, $urandom(), 1'b1);
    push_frame(5, $urandom(), 1'b1);
    drain(400);

    // Asynchronous reset with one frame playing and the next one mid-fill.
    rdy_mode = 0;
    push_frame(20, 32'hC000_0000, 1'b1);
    push_frame(20, 32'hD000_0000, 1'b1);
    repeat (30) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tready",        32'(s_axis_tready), 32'd1);
    chk("rst_dac_valid",     32'(dac_valid),     32'd0);
    chk("rst_dac_data",      dac_data,           32'd0);
    chk("rst_frame_ready",   32'(frame_ready),   32'd0);
    chk("rst_underrun",      32'(underrun),      32'd0);
    chk("rst_tlast_err",     32'(tlast_err),     32'd0);
    chk("rst_frames_played", 32'(frames_played), 32'd0);
    src_q.delete();
    model_reset();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_frame(2, 32'hBEEF_0000, 1'b1);
    drain(200);

    // Single-beat frame.
    push_frame(1, 32'h1234_5678, 1'b1);
    drain(200);

    // Back-to-back short frames with DAC always ready: seamless frame changes.
    for (int f = 0; f < 6; f++) push_frame($urandom_range(1, 12), $urandom(), 1'b1);
    drain(2000);

    // Random lengths, random valid and random DAC readiness.
    rdy_mode = 2;
    vld_pct  = 70;
    for (int f = 0; f < 20; f++) push_frame($urandom_range(1, 40), $urandom(), 1'b1);
    drain(20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
